dmem_responder: RTL

- Data-memory responder on the CPU's load/store interface: the memory end of the ALU_result / Out2 / MemWrite / MemtoReg → DataToWd path, replacing the bench's constant DataToWd = 0.
- Word-organised RAM with a configurable wait-state counter, a single-cycle Ready pulse and misalignment detection.
- Sits beside MIPS_CPU at top level, opposite INST_ROM on the data side.

---
 rtl/dmem_responder.sv | 77 +++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM answering CPU loads/stores after WAIT_STATES
// extra cycles with a one-cycle Ready pulse and misalignment flag.
module dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Out2,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    output logic [31:0] DataToWd,
    output logic        Ready,
    output logic        Misaligned
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                 r_state, w_next;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS+1:0]   r_addr;
    logic [31:0]            r_data;
    logic                   r_wr;
    logic [31:0]            r_mem [2**ADDR_BITS];
    logic                   w_accept, w_commit, w_wr, w_ok, w_unused;
    logic [ADDR_BITS+1:0]   w_addr;
    logic [31:0]            w_data;
    logic [ADDR_BITS-1:0]   w_idx;
    // High address bits are don't-care so the index wraps modulo the depth.
    assign w_unused = ^ALU_result[31:ADDR_BITS+2];
    assign w_accept = (r_state == IDLE) && (MemWrite || MemtoReg);
    // With zero wait states the commit edge is the accept edge, so use live inputs in IDLE.
    assign w_addr   = (r_state == IDLE) ? ALU_result[ADDR_BITS+1:0] : r_addr;
    assign w_data   = (r_state == IDLE) ? Out2 : r_data;
    assign w_wr     = (r_state == IDLE) ? MemWrite : r_wr;
    assign w_idx    = w_addr[ADDR_BITS+1:2];
    assign w_ok     = (w_addr[1:0] == 2'b00);
    assign w_commit = Reset && (w_next == RESP) && (r_state != RESP);
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_wr     <= 1'b0;
            DataToWd <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt  <= 4'(WAIT_STATES);
                r_addr <= ALU_result[ADDR_BITS+1:0];
                r_data <= Out2;
                r_wr   <= MemWrite;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !w_wr && w_ok)
                DataToWd <= r_mem[w_idx];
        end
    end
    // RAM has no reset: contents persist across Reset.
    always_ff @(posedge Clock) begin
        if (w_commit && w_wr && w_ok)
            r_mem[w_idx] <= w_data;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (r_cnt <= 4'd1) w_next = RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        Ready      = (r_state == RESP);
        Misaligned = (r_state == RESP) && (r_addr[1:0] != 2'b00);
    end
endmodule
